// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one round per clock on a single round datapath,
// fed by an externally expanded key schedule, with valid/ready on both sides.
module aes_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [4*(Nr+1)-1:0][31:0]    rkey,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [127:0]                 pt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [127:0]                 ct
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [3:0] LAST_RND = 4'(Nr);

   // Block layout: byte k of the FIPS-197 byte stream sits at bits [8k+7:8k];
   // state row r, column c is byte r+4c.

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (x & {8{b[i]}});
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as SubBytes requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2;
      logic [7:0] a3;
      logic [7:0] a12;
      logic [7:0] a15;
      logic [7:0] a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a12  = gmul(gmul(a3, a3), gmul(a3, a3));
      a15  = gmul(a12, a3);
      a240 = gmul(a15, a15);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      logic [7:0] c;
      logic [7:0] o;
      logic [2:0] k;
      v = gf_inv(a);
      c = 8'h63;
      o = 8'h00;
      for (int i = 0; i < 8; i++) begin
         k = 3'(i);
         o[k] = v[k] ^ v[k + 3'd4] ^ v[k + 3'd5] ^ v[k + 3'd6] ^ v[k + 3'd7] ^ c[k];
      end
      return o;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) begin
         o[8*k +: 8] = sbox(s[8*k +: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   logic [1:0]   state_r;
   logic [3:0]   rnd_r;
   logic [127:0] st_r;
   logic         out_valid_r;
   logic [127:0] rk_s;
   logic [127:0] rk0_s;
   logic [127:0] sr_s;
   logic [127:0] mc_s;
   logic [127:0] round_s;

   assign rk_s  = rkey[{rnd_r, 2'b00} +: 4];
   assign rk0_s = rkey[3:0];

   // Single round datapath; the final round bypasses MixColumns.
   always_comb begin
      sr_s = shift_rows(sub_bytes(st_r));
      mc_s = mix_columns(sr_s);
      if (rnd_r == LAST_RND) begin
         round_s = sr_s ^ rk_s;
      end else begin
         round_s = mc_s ^ rk_s;
      end
   end

   // Accepts may coincide with the handoff edge, so DONE with out_ready is also ready.
   assign in_ready  = rst_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
   assign out_valid = out_valid_r;
   assign ct        = st_r;

   // Control FSM, round counter and state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rnd_r       <= 4'd0;
         st_r        <= 128'd0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  st_r    <= pt ^ rk0_s;
                  rnd_r   <= 4'd1;
                  state_r <= ROUND;
               end
            end
            ROUND: begin
               st_r <= round_s;
               if (rnd_r == LAST_RND) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  rnd_r <= rnd_r + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (in_valid) begin
                     st_r    <= pt ^ rk0_s;
                     rnd_r   <= 4'd1;
                     state_r <= ROUND;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               rnd_r       <= 4'd0;
               st_r        <= 128'd0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative, area-reduced AES forward cipher (encryption) core. It processes one 128-bit block at a time, performing one round per clock with a single round datapath. It takes a pre-expanded round-key schedule and uses the aes_pkg forward transforms (SubBytes, ShiftRows, MixColumns, AddRoundKey). A valid/ready handshake on each side lets it sit between a block source and a ciphertext sink, including where the sink applies backpressure.

## Interface
- Nk, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
- Nr, default Nk+6: number of rounds (10, 12 or 14).

- clk  input  1  the only clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- rkey  input  32 x 4*(Nr+1)  expanded key schedule. Round key i = {rkey[4i+3], rkey[4i+2], rkey[4i+1], rkey[4i]}.
- in_valid  input  1  pt is valid.
- in_ready  output  1  the core accepts pt this cycle.
- pt  input  128  plaintext block, in aes_pkg block layout.
- out_valid  output  1  ct holds a completed ciphertext.
- out_ready  input  1  the sink accepts ct this cycle.
- ct  output  128  ciphertext block.

## Operation
- There is no internal key storage. rkey must be stable from the accepting edge until the result is handed off. Changing rkey mid-block gives an undefined ct; this is not an error condition.
- State machine:
  - IDLE → ROUND on accept (in_valid && in_ready).
  - ROUND → DONE when rnd == Nr.
  - DONE → IDLE on out_ready && !in_valid.
  - DONE → ROUND on out_ready && in_valid (handoff and accept on the same edge).
  - DONE → DONE otherwise.
- Registers:
  - 128-bit st (drives ct directly).
  - 4-bit rnd counter, range 1..Nr.
  - FSM state.
- Accept edge: st ← AddRoundKey(pt, rk[0]); rnd ← 1.
- ROUND, rnd < Nr: st ← AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk[rnd]); rnd ← rnd+1.
- ROUND, rnd == Nr (final round, no MixColumns): st ← AddRoundKey(ShiftRows(SubBytes(st)), rk[Nr]); go to DONE.
- Round-key selection is a mux on rnd over the Nr+1 packed keys. rnd never exceeds Nr.
- in_ready = rst_n && (state == IDLE || (state == DONE && out_ready)). It is combinational and 0 in ROUND.
- out_valid = (state == DONE), registered.
- ct = st.
  - Stable while out_valid && !out_ready.
  - Holds the last result in IDLE.
  - Not meaningful while in ROUND.
- in_valid without in_ready: pt is ignored; the source must hold it.
- out_ready while not out_valid: no effect.

## Timing
- Reset values, on any edge with rst_n low: state = IDLE, rnd = 0, st/ct = 0, out_valid = 0. in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- Reset mid-operation (ROUND or DONE): the block in flight is discarded with no output. The core behaves exactly as after power-on reset.
- Latency: out_valid rises Nr edges after the accepting edge (10 for AES-128, 12 for AES-192, 14 for AES-256).
- Throughput: with continuous in_valid and out_ready, one block every Nr+1 clocks. The next accept coincides with the previous handoff edge.
- Backpressure: DONE persists indefinitely. ct and out_valid stay constant, and in_ready stays 0 until out_ready.
- No combinational path from in_valid to in_ready or out_valid. The only combinational input-to-output path is out_ready → in_ready.

## Test plan
All vectors are in FIPS-197 byte order. The bench packs them into aes_pkg layout and supplies rkey from a software key expansion.

- Reset: hold rst_n low for 3 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, ct = 0, and nothing is accepted. After release, in_ready = 1 in the first cycle.
- AES-128 (Nk=4):
  - Input: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready = 1.
  - Required: ct = 3925841d02dc09fbdc118597196a0b32, with out_valid high exactly 10 edges after accept and for exactly 1 cycle.
- Backpressure:
  - Input: key 000102…0f, pt 00112233445566778899aabbccddeeff, out_ready held low for 5 cycles after out_valid rises.
  - Required: ct = 69c4e0d86a7b0430d8cdb78070b4c55a, stable all 5 cycles, and in_ready = 0 throughout.
- Back-to-back: 4 blocks with in_valid and out_ready tied high → accepts spaced exactly 11 cycles apart, each ct correct, no gap cycles.
- Reset mid-round: pulse rst_n low for one edge at rnd = 5, then submit the Appendix B vector → no output from the aborted block, and the new block gives the correct ct 10 edges after its accept.
- Parameter sweep:
  - Nk=6 with key 000102…17 → ct dda97ca4864cdfe06eaf70a0ec0d7191, latency 12.
  - Nk=8 with key 000102…1f → ct 8ea2b7ca516745bfeafc49904b496089, latency 14.
  - Both use pt 00112233445566778899aabbccddeeff.
